// File: rtl/alu_arb_pkg.sv
// Shared definitions for the two-requester ALU arbiter: FSM state encoding and ALU op codes.
package alu_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_RSVD = 3'b011;
    localparam logic [2:0] OP_ANDN = 3'b100;
    localparam logic [2:0] OP_ORN  = 3'b101;
    localparam logic [2:0] OP_SUB  = 3'b110;
    localparam logic [2:0] OP_SLT  = 3'b111;

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU; the reserved op yields a zero result and flags an error.
module alu_core
    import alu_arb_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [2:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] result,
    output logic         zero,
    output logic         err
);

    always_comb begin
        result = '0;
        err    = 1'b0;
        case (op)
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_ADD:  result = a + b;
            OP_RSVD: err    = 1'b1;
            OP_ANDN: result = a & ~b;
            OP_ORN:  result = a | ~b;
            OP_SUB:  result = a - b;
            OP_SLT:  result = {{(N-1){1'b0}}, (a < b)};
            default: result = '0;
        endcase
        zero = (result == '0);
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter feeding one shared ALU; one transaction in flight (IDLE -> EXEC -> RESP).
// Handshakes: a transfer happens on a rising edge where valid & ready are both high; resp_* hold until taken.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [1:0]   req_valid,
    output logic [1:0]   req_ready,
    input  logic [2:0]   req0_op,
    input  logic [N-1:0] req0_a,
    input  logic [N-1:0] req0_b,
    input  logic [2:0]   req1_op,
    input  logic [N-1:0] req1_a,
    input  logic [N-1:0] req1_b,
    output logic         resp_valid,
    input  logic         resp_ready,
    output logic         resp_id,
    output logic [N-1:0] resp_result,
    output logic         resp_zero,
    output logic         resp_err,
    output logic [1:0]   dbg_state
);

    state_t       state, state_nxt;
    logic         last_grant;
    logic         grant_id;
    logic         accept;
    logic [2:0]   op_q;
    logic [N-1:0] a_q, b_q;
    logic         id_q;
    logic [N-1:0] alu_result;
    logic         alu_zero, alu_err;

    // With both requesting, the one not served last wins; a lone requester always wins.
    always_comb begin
        grant_id = req_valid[1];
        if (req_valid == 2'b11) grant_id = ~last_grant;
    end

    always_comb begin
        req_ready = 2'b00;
        if (rst_n && state == ST_IDLE && req_valid != 2'b00)
            req_ready = grant_id ? 2'b10 : 2'b01;
    end

    assign accept     = |(req_valid & req_ready);
    assign resp_valid = (state == ST_RESP);
    assign dbg_state  = state;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept) state_nxt = ST_EXEC;
            ST_EXEC: state_nxt = ST_RESP;
            ST_RESP: if (resp_ready) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    alu_core #(.N(N)) u_alu (
        .op     (op_q),
        .a      (a_q),
        .b      (b_q),
        .result (alu_result),
        .zero   (alu_zero),
        .err    (alu_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            last_grant  <= 1'b1;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            id_q        <= 1'b0;
            resp_id     <= 1'b0;
            resp_result <= '0;
            resp_zero   <= 1'b0;
            resp_err    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                last_grant <= grant_id;
                id_q       <= grant_id;
                op_q       <= grant_id ? req1_op : req0_op;
                a_q        <= grant_id ? req1_a  : req0_a;
                b_q        <= grant_id ? req1_b  : req0_b;
            end
            // Response registers only load in EXEC, so they stay frozen through RESP backpressure.
            if (state == ST_EXEC) begin
                resp_id     <= id_q;
                resp_result <= alu_result;
                resp_zero   <= alu_zero;
                resp_err    <= alu_err;
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: hand-computed vectors checked with immediate assertions.
module tb_alu_arbiter;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [1:0]   req_valid;
    logic [1:0]   req_ready;
    logic [2:0]   req0_op, req1_op;
    logic [N-1:0] req0_a, req0_b, req1_a, req1_b;
    logic         resp_valid;
    logic         resp_ready;
    logic         resp_id;
    logic [N-1:0] resp_result;
    logic         resp_zero;
    logic         resp_err;
    logic [1:0]   dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.N(N)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req0_op     (req0_op),
        .req0_a      (req0_a),
        .req0_b      (req0_b),
        .req1_op     (req1_op),
        .req1_a      (req1_a),
        .req1_b      (req1_b),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_id     (resp_id),
        .resp_result (resp_result),
        .resp_zero   (resp_zero),
        .resp_err    (resp_err),
        .dbg_state   (dbg_state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one transaction from IDLE, assuming req_valid/operands are already driven and resp_ready=1.
    task automatic txn(input string tag, input int g, input logic [7:0] res,
                       input logic z, input logic e);
        #1;
        chk({tag, "_grant"}, {30'd0, req_ready}, (g == 0) ? 32'd1 : 32'd2);
        step();
        chk({tag, "_exec_rdy"}, {30'd0, req_ready}, 32'd0);
        chk({tag, "_exec_vld"}, {31'd0, resp_valid}, 32'd0);
        step();
        chk({tag, "_vld"}, {31'd0, resp_valid}, 32'd1);
        chk({tag, "_id"}, {31'd0, resp_id}, g[31:0]);
        chk({tag, "_res"}, {24'd0, resp_result}, {24'd0, res});
        chk({tag, "_zero"}, {31'd0, resp_zero}, {31'd0, z});
        chk({tag, "_err"}, {31'd0, resp_err}, {31'd0, e});
        step();
        chk({tag, "_idle_vld"}, {31'd0, resp_valid}, 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_ready", {30'd0, req_ready}, 32'd0);
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 2'b11; resp_ready = 1'b1;
        req0_op = 3'b000; req0_a = '0; req0_b = '0;
        req1_op = 3'b000; req1_a = '0; req1_b = '0;
        #2;
        chk("rst_vld", {31'd0, resp_valid}, 32'd0);
        chk("rst_res", {24'd0, resp_result}, 32'd0);
        chk("rst_zero", {31'd0, resp_zero}, 32'd0);
        chk("rst_err", {31'd0, resp_err}, 32'd0);
        chk("rst_id", {31'd0, resp_id}, 32'd0);
        chk("rst_state", {30'd0, dbg_state}, 32'd0);
        do_reset();

        // Single request; operands scrambled after the accept edge must not matter.
        req_valid = 2'b01; req0_op = 3'b010; req0_a = 8'h0F; req0_b = 8'h01;
        #1;
        chk("single_grant", {30'd0, req_ready}, 32'd1);
        step();
        req_valid = 2'b00; req0_op = 3'b110; req0_a = 8'h77; req0_b = 8'h99;
        chk("single_exec_vld", {31'd0, resp_valid}, 32'd0);
        step();
        chk("single_vld", {31'd0, resp_valid}, 32'd1);
        chk("single_res", {24'd0, resp_result}, 32'h10);
        chk("single_id", {31'd0, resp_id}, 32'd0);
        chk("single_zero", {31'd0, resp_zero}, 32'd0);
        chk("single_err", {31'd0, resp_err}, 32'd0);
        step();
        chk("single_idle", {31'd0, resp_valid}, 32'd0);

        // Contention from fresh reset: grants alternate 0,1,0,1 with a 3-cycle cadence.
        do_reset();
        req_valid = 2'b11;
        req0_op = 3'b110; req0_a = 8'd5; req0_b = 8'd5;
        req1_op = 3'b110; req1_a = 8'd3; req1_b = 8'd4;
        txn("cont0", 0, 8'h00, 1'b1, 1'b0);
        txn("cont1", 1, 8'hFF, 1'b0, 1'b0);
        txn("cont2", 0, 8'h00, 1'b1, 1'b0);
        txn("cont3", 1, 8'hFF, 1'b0, 1'b0);

        // Single requesters with assorted ops (last grant was 1, requester 1 alone still wins).
        req_valid = 2'b10; req1_op = 3'b011; req1_a = 8'hAA; req1_b = 8'h55;
        txn("rsvd", 1, 8'h00, 1'b1, 1'b1);
        req_valid = 2'b01; req0_op = 3'b111; req0_a = 8'd3; req0_b = 8'd200;
        txn("slt_t", 0, 8'h01, 1'b0, 1'b0);
        req0_a = 8'd200; req0_b = 8'd3;
        txn("slt_f", 0, 8'h00, 1'b1, 1'b0);
        req0_op = 3'b101; req0_a = 8'h00; req0_b = 8'hF0;
        txn("orn", 0, 8'h0F, 1'b0, 1'b0);
        req0_op = 3'b100; req0_a = 8'hFF; req0_b = 8'h0F;
        txn("andn", 0, 8'hF0, 1'b0, 1'b0);
        req0_op = 3'b001; req0_a = 8'hA0; req0_b = 8'h05;
        txn("or", 0, 8'hA5, 1'b0, 1'b0);
        req0_op = 3'b010; req0_a = 8'hFF; req0_b = 8'h01;
        txn("add_wrap", 0, 8'h00, 1'b1, 1'b0);

        // Backpressure: response held for 5 cycles with both requesters waiting.
        req_valid = 2'b11; resp_ready = 1'b0;
        req0_op = 3'b000; req0_a = 8'hF0; req0_b = 8'h3C;
        req1_op = 3'b000; req1_a = 8'h0F; req1_b = 8'h0F;
        #1;
        chk("bp_grant", {30'd0, req_ready}, 32'd2);
        step();
        step();
        for (int i = 0; i < 5; i++) begin
            chk("bp_vld", {31'd0, resp_valid}, 32'd1);
            chk("bp_res", {24'd0, resp_result}, 32'h0F);
            chk("bp_id", {31'd0, resp_id}, 32'd1);
            chk("bp_rdy", {30'd0, req_ready}, 32'd0);
            step();
        end
        resp_ready = 1'b1;
        #1;
        chk("bp_last_vld", {31'd0, resp_valid}, 32'd1);
        step();
        chk("bp_idle_state", {30'd0, dbg_state}, 32'd0);
        chk("bp_idle_vld", {31'd0, resp_valid}, 32'd0);
        chk("bp_next_grant", {30'd0, req_ready}, 32'd1);

        // Reset during EXEC aborts; after release requester 0 gets first priority.
        step();
        chk("rx_exec_state", {30'd0, dbg_state}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rx_rst_rdy", {30'd0, req_ready}, 32'd0);
        chk("rx_rst_vld", {31'd0, resp_valid}, 32'd0);
        step();
        rst_n = 1'b1; req_valid = 2'b00;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rx_no_resp", {31'd0, resp_valid}, 32'd0);
        end
        req_valid = 2'b11;
        req0_op = 3'b010; req0_a = 8'd20; req0_b = 8'd22;
        txn("rx_first", 0, 8'd42, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: N, default 8, operand/result width in bits.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req_valid  input  2  per-requester request valid; bit i = requester i.
REQ-005 req_ready  output  2  per-requester accept; at most one bit high per cycle.
REQ-006 req0_op, req1_op  input  3 each  ALU op code of requester 0/1.
REQ-007 req0_a, req0_b, req1_a, req1_b  input  N each  operands of requester 0/1.
REQ-008 resp_valid  output  1  result available.
REQ-009 resp_ready  input  1  consumer accepts result.
REQ-010 resp_id  output  1  index of requester that owns the result.
REQ-011 resp_result  output  N  ALU result.
REQ-012 resp_zero  output  1  high when resp_result is all zeros.
REQ-013 resp_err  output  1  high when op was reserved code 3'b011.

Function
REQ-014 FSM states: IDLE, EXEC, RESP; encoding in the shared package.
REQ-015 IDLE: if any req_valid bit is high, assert req_ready for the granted requester only, combinationally from req_valid and the priority pointer.
REQ-016 Grant: round-robin; if both valid, requester != last_grant wins; single valid requester always wins.
REQ-017 Transfer on req_valid[i] & req_ready[i]: latch op, a, b, id; update last_grant to i; go to EXEC.
REQ-018 req_ready is 0 in EXEC and RESP; no request accepted while a transaction is in flight.
REQ-019 EXEC: compute result from latched operands, register result/zero/err/id; go to RESP next cycle.
REQ-020 Ops: 000 A&B; 001 A|B; 010 A+B mod 2^N; 011 reserved -> result 0, err=1; 100 A&~B; 101 A|~B; 110 A-B mod 2^N; 111 unsigned A<B, zero-extended to N bits.
REQ-021 err=0 for all non-reserved ops; zero flag computed on final result, including reserved (zero=1).
REQ-022 RESP: resp_valid=1; resp_id/result/zero/err held stable until resp_valid & resp_ready.
REQ-023 On resp handshake, go to IDLE; the next grant occurs no earlier than the following cycle (IDLE cycle).
REQ-024 Latency: request accept edge to resp_valid high = 2 cycles; throughput at most one transaction per 3 cycles.
REQ-025 resp_valid low in IDLE and EXEC.
REQ-026 Requester-side req_valid deassertion without handshake is legal and produces no transaction.
REQ-027 Operand changes after the accept edge do not affect the in-flight result.

Reset
REQ-028 rst_n low: state=IDLE, last_grant=1 (requester 0 has first priority), resp_valid=0, resp_result=0, resp_zero=0, resp_err=0, resp_id=0, latched operands=0.
REQ-029 Reset asserted during EXEC or RESP aborts the transaction; no response is produced after release.
REQ-030 req_ready is 0 while rst_n is low.

Structure
REQ-031 Shared package alu_arb_pkg holds the FSM state typedef and op code constants (OP_AND .. OP_SLT, OP_RSVD=3'b011).
REQ-032 Combinational ALU in one sub-module alu_core (parameter N; inputs op, a, b; outputs result, zero, err); arbiter instantiates it once.

Verification
REQ-033 Single request: req_valid=01, op=010, a=8'h0F, b=8'h01 -> accept cycle 0, resp_valid cycle 2, result 8'h10, id 0, zero 0, err 0.
REQ-034 Contention: both valid continuously, each op=110 (req0 a=5 b=5; req1 a=3 b=4) -> grants alternate 0,1,0,...; req0 result 0 zero=1; req1 result 8'hFF.
REQ-035 Reserved op: op=011, a=8'hAA, b=8'h55 -> result 0, zero 1, err 1.
REQ-036 Backpressure: resp_ready=0 for 5 cycles in RESP -> outputs stable, req_ready=00 throughout; resp_ready=1 -> IDLE next cycle.
REQ-037 SLT/bitwise: op=111 a=3 b=200 -> result 1; op=101 a=8'h00 b=8'hF0 -> result 8'h0F.
REQ-038 Reset mid-EXEC: rst_n low during EXEC -> resp_valid never asserts; after release, first grant goes to requester 0 when both valid.
